// File: rtl/nncu_pkg.sv
// Shared constants for the NN memory arbiter slice: arbitration mode
// encodings, conventional channel indices and default bus widths.
package nncu_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam int CH_FP   = 0;
  localparam int CH_BP   = 1;
  localparam int CH_HOST = 2;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

endpackage

// File: rtl/nncu_rr_picker.sv
// Rotate-priority one-hot selector: the first set bit of req at or after
// base (wrapping) wins. With base tied to 0 it is a plain lowest-index
// priority encoder.
module nncu_rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] base,
  output logic [N-1:0]     onehot
);

  // scan N positions starting at base, keep the first requester
  always_comb begin
    logic found;
    int   idx;
    onehot = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nncu_mem_arbiter.sv
// N-channel arbiter in front of the shared single-port NN memory.
// Grant priority: lock owner, then starved channel (fixed mode only), then
// fixed lowest-index or round-robin winner. Read data returns with a tag
// pipeline so rvalid reaches the channel that issued the read.
// Optional grant statistics are built when NNCU_ARB_STATS_EN is defined.
module nncu_mem_arbiter
  import nncu_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = nncu_pkg::ADDR_W,
  parameter int DATA_W     = nncu_pkg::DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8,
  parameter int LOCK_MAX   = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rr_mode,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        lock,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef NNCU_ARB_STATS_EN
  ,
  input  logic [CH_W-1:0]          stat_sel,
  input  logic                     stat_clr,
  output logic [31:0]              stat_cnt
`endif
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_LIM);
  localparam logic [LC_W-1:0] LOCK_TOP   = LC_W'(LOCK_MAX);

  logic [CH_W-1:0]   rr_ptr;
  logic [SC_W-1:0]   starve_cnt [NUM_CH];
  logic              lock_vld;
  logic [CH_W-1:0]   lock_own;
  logic [LC_W-1:0]   lock_cnt;
  logic              tag_vld [RD_LAT];
  logic [CH_W-1:0]   tag_ch  [RD_LAT];

  logic [NUM_CH-1:0] own_oh;
  logic              owner_hold;
  logic              lock_hit;
  logic              lock_force;
  logic [NUM_CH-1:0] excl;
  logic [NUM_CH-1:0] req_ok;
  logic [NUM_CH-1:0] starved;
  logic [NUM_CH-1:0] starve_pick;
  logic [NUM_CH-1:0] mode_pick;
  logic [CH_W-1:0]   mode_base;
  logic [CH_W-1:0]   gnt_idx;

  // one-hot view of the current lock owner
  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NUM_CH; i++) own_oh[i] = (lock_own == CH_W'(i));
  end

  // An owner that keeps req+lock wins until LOCK_MAX grants; the cycle it
  // hits the limit it is masked out so another channel gets a turn.
  assign owner_hold = lock_vld && |(own_oh & req & lock);
  assign lock_hit   = owner_hold && (lock_cnt < LOCK_TOP);
  assign lock_force = owner_hold && !lock_hit;
  assign excl       = lock_force ? own_oh : '0;
  assign req_ok     = req & ~excl;

  // channels whose wait counter saturated (counters stay 0 in rr mode)
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_CH; i++)
      starved[i] = (rr_mode == ARB_FIXED) && req_ok[i] && (starve_cnt[i] == STARVE_TOP);
  end

  assign mode_base = (rr_mode == ARB_RR) ? rr_ptr : '0;

  nncu_rr_picker #(.N(NUM_CH), .PTR_W(CH_W)) u_starve_pick (
    .req    (starved),
    .base   ('0),
    .onehot (starve_pick)
  );

  nncu_rr_picker #(.N(NUM_CH), .PTR_W(CH_W)) u_mode_pick (
    .req    (req_ok),
    .base   (mode_base),
    .onehot (mode_pick)
  );

  // final grant in priority order: lock, starvation, mode winner
  always_comb begin
    if (lock_hit)      gnt = own_oh;
    else if (|starved) gnt = starve_pick;
    else               gnt = mode_pick;
  end

  // encode grant and steer the granted channel onto the memory port
  always_comb begin
    gnt_idx   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) gnt_idx = CH_W'(i);
      mem_addr  = mem_addr  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt[i]}});
      mem_wdata = mem_wdata | (wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
    end
  end

  assign mem_en = |gnt;
  assign mem_we = |(gnt & we);
  assign rdata  = mem_rdata;

  // round-robin pointer moves past each winner, frozen during lock streaks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (mem_en && !lock_hit) begin
      rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  // per-channel wait counters, saturating, fixed mode only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rr_mode == ARB_RR || !req[i] || gnt[i])
          starve_cnt[i] <= '0;
        else if (starve_cnt[i] != STARVE_TOP)
          starve_cnt[i] <= starve_cnt[i] + SC_W'(1);
      end
    end
  end

  // lock ownership: taken by any locked grant, dropped otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_vld <= 1'b0;
      lock_own <= '0;
      lock_cnt <= '0;
    end else if (|(gnt & lock)) begin
      lock_vld <= 1'b1;
      lock_own <= gnt_idx;
      lock_cnt <= lock_hit ? lock_cnt + LC_W'(1) : LC_W'(1);
    end else begin
      lock_vld <= 1'b0;
      lock_cnt <= '0;
    end
  end

  // read tag pipeline, one stage per cycle of memory read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_ch[k]  <= '0;
      end
    end else begin
      tag_vld[0] <= mem_en && !mem_we;
      tag_ch[0]  <= gnt_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_ch[k]  <= tag_ch[k-1];
      end
    end
  end

  // decode the oldest tag into the per-channel rvalid pulse
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_CH; i++)
      rvalid[i] = tag_vld[RD_LAT-1] && (tag_ch[RD_LAT-1] == CH_W'(i));
  end

`ifdef NNCU_ARB_STATS_EN
  logic [31:0] stat_ctr [NUM_CH];
  logic [31:0] stat_mux;

  // saturating grant counters, synchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) stat_ctr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stat_clr)
          stat_ctr[i] <= '0;
        else if (gnt[i] && stat_ctr[i] != 32'hFFFF_FFFF)
          stat_ctr[i] <= stat_ctr[i] + 32'd1;
      end
    end
  end

  // select the requested channel's counter
  always_comb begin
    stat_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (stat_sel == CH_W'(i)) stat_mux = stat_ctr[i];
  end

  // registered readout, one cycle behind the selection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stat_cnt <= '0;
    else      stat_cnt <= stat_mux;
  end
`endif

endmodule

// File: tb/tb_nncu_mem_arbiter.sv
// Directed bench for nncu_mem_arbiter (3 channels, read latency 2).
// Stats checks are included when NNCU_ARB_STATS_EN is defined.
module tb_nncu_mem_arbiter;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic                     clk;
  logic                     rst;
  logic                     rr_mode;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        lock;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
`ifdef NNCU_ARB_STATS_EN
  logic [1:0]               stat_sel;
  logic                     stat_clr;
  logic [31:0]              stat_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] exp3;

  nncu_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rr_mode   (rr_mode),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef NNCU_ARB_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    req  = r;
    lock = l;
    we   = w;
  endtask

  initial begin
    rst       = 1'b0;
    rr_mode   = 1'b0;
    req       = '0;
    lock      = '0;
    we        = '0;
    mem_rdata = '0;
    addr      = {16'h0080, 16'h0040, 16'h0010};
    wdata     = {16'hC2C2, 16'hB1B1, 16'hA0A0};
`ifdef NNCU_ARB_STATS_EN
    stat_sel  = 2'd0;
    stat_clr  = 1'b0;
`endif

    // reset state
    tick(); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b1;

    // fixed priority with starvation: ch1/ch2 counters reach 8 after eight
    // ungranted cycles, ch1 wins the tie, ch2 follows, then ch0 again
    for (int c = 0; c < 11; c++) begin
      tick(); drive(3'b111, 3'b000, 3'b111); #1;
      exp3 = (c < 8) ? 3'b001 : (c == 8) ? 3'b010 : (c == 9) ? 3'b100 : 3'b001;
      chk("fixed_gnt", 32'(gnt), 32'(exp3));
      chk("write_no_rvalid", 32'(rvalid), 32'h0);
      if (c == 8) begin
        chk("starve_mem_addr", 32'(mem_addr), 32'h0040);
        chk("starve_mem_we", 32'(mem_we), 32'h1);
        chk("starve_mem_wdata", 32'(mem_wdata), 32'hB1B1);
      end
    end
    tick(); drive(3'b000, 3'b000, 3'b000); #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_mem_en", 32'(mem_en), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    chk("idle_mem_wdata", 32'(mem_wdata), 32'h0);

    // fresh pointer for round robin
    rst = 1'b0; #2; rst = 1'b1;

    rr_mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(); drive(3'b111, 3'b000, 3'b111); #1;
      exp3 = 3'b001 << (c % 3);
      chk("rr_gnt", 32'(gnt), 32'(exp3));
    end
    tick(); drive(3'b000, 3'b000, 3'b000); rr_mode = 1'b0;

    // ch1 read, data returns two cycles later
    tick(); drive(3'b010, 3'b000, 3'b000); #1;
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_mem_en", 32'(mem_en), 32'h1);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0040);
    tick(); drive(3'b000, 3'b000, 3'b000); #1;
    chk("rd_early", 32'(rvalid), 32'h0);
    tick(); mem_rdata = 16'hBEEF; #1;
    chk("rd_rvalid", 32'(rvalid), 32'h2);
    chk("rd_rdata", 32'(rdata), 32'hBEEF);
    tick(); mem_rdata = 16'h0000; #1;
    chk("rd_pulse_end", 32'(rvalid), 32'h0);

    // back-to-back reads ch0 then ch2 return in grant order
    tick(); drive(3'b101, 3'b000, 3'b000); #1;
    chk("b2b_gnt0", 32'(gnt), 32'h1);
    tick(); drive(3'b100, 3'b000, 3'b000); #1;
    chk("b2b_gnt2", 32'(gnt), 32'h4);
    chk("b2b_rv_none", 32'(rvalid), 32'h0);
    tick(); drive(3'b000, 3'b000, 3'b000); #1;
    chk("b2b_rv0", 32'(rvalid), 32'h1);
    tick(); #1;
    chk("b2b_rv2", 32'(rvalid), 32'h4);
    tick(); #1;
    chk("b2b_rv_done", 32'(rvalid), 32'h0);

    // a write never returns rvalid
    tick(); drive(3'b100, 3'b000, 3'b100); #1;
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    tick(); drive(3'b000, 3'b000, 3'b000); #1;
    chk("wr_rv1", 32'(rvalid), 32'h0);
    tick(); #1;
    chk("wr_rv2", 32'(rvalid), 32'h0);

    // ch1 locks for 16 grants despite ch0, ch0 takes the forced gap,
    // ch1 locks again, then dropping lock lets ch0 win
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c == 0)       drive(3'b010, 3'b010, 3'b011);
      else if (c <= 16) drive(3'b011, 3'b010, 3'b011);
      else              drive(3'b010, 3'b010, 3'b011);
      #1;
      exp3 = (c == 16) ? 3'b001 : 3'b010;
      chk("lock_gnt", 32'(gnt), 32'(exp3));
    end
    tick(); drive(3'b011, 3'b000, 3'b011); #1;
    chk("lock_release", 32'(gnt), 32'h1);
    tick(); drive(3'b000, 3'b000, 3'b000);

    // two reads in flight, reset drops both
    tick(); drive(3'b001, 3'b000, 3'b000); #1;
    chk("flush_gnt0", 32'(gnt), 32'h1);
    tick(); drive(3'b100, 3'b000, 3'b000); #1;
    chk("flush_gnt2", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3'b000, 3'b000, 3'b000);
    #1;
    chk("flush_rst_rvalid", 32'(rvalid), 32'h0);
    chk("flush_rst_gnt", 32'(gnt), 32'h0);
    chk("flush_rst_mem_en", 32'(mem_en), 32'h0);
    tick(); rst = 1'b1; #1;
    chk("flush_rv_a", 32'(rvalid), 32'h0);
    tick(); #1;
    chk("flush_rv_b", 32'(rvalid), 32'h0);
    tick(); #1;
    chk("flush_rv_c", 32'(rvalid), 32'h0);
    chk("flush_mem_en", 32'(mem_en), 32'h0);

`ifdef NNCU_ARB_STATS_EN
    // five grants to ch2, readout one cycle behind, then clear
    stat_sel = 2'd2;
    for (int c = 0; c < 5; c++) begin
      tick(); drive(3'b100, 3'b000, 3'b100); #1;
      chk("stat_gnt", 32'(gnt), 32'h4);
    end
    tick(); drive(3'b000, 3'b000, 3'b000);
    tick(); #1;
    chk("stat_cnt5", stat_cnt, 32'd5);
    tick(); stat_clr = 1'b1;
    tick(); stat_clr = 1'b0;
    tick(); #1;
    chk("stat_cnt_clr", stat_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
